// File: rtl/entity_frame_publisher.sv
// Entity frame publisher: game logic fills a shadow bank of nine entity words,
// and the whole bank is copied to the PPU-facing outputs in one cycle per frame
// so the renderer never sees a half-updated entity set.
module entity_frame_publisher #(
    parameter logic [3:0] EMPTY_ID  = 4'hF,
    parameter int         OVERRUN_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [3:0]           wr_slot,
    input  logic [17:0]          wr_data,
    input  logic                 batch_open,
    input  logic                 frame_tick,
    output logic [13:0]          entity_1,
    output logic [13:0]          entity_2,
    output logic [13:0]          entity_3,
    output logic [13:0]          entity_4,
    output logic [13:0]          entity_5,
    output logic [13:0]          entity_6,
    output logic [17:0]          entity_7,
    output logic [13:0]          entity_8_Flip,
    output logic [13:0]          entity_9_Flip,
    output logic                 frame_committed,
    output logic                 commit_pending,
    output logic                 bad_slot,
    output logic [OVERRUN_W-1:0] overrun_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BATCH = 2'd1,
        COMMIT     = 2'd2
    } state_t;

    // Low 14 bits of every slot share one array; slot 7 keeps its extra
    // top nibble separately so no slot carries unused storage.
    localparam logic [13:0] EMPTY_WORD = {EMPTY_ID, 10'b0};

    state_t                state_q, state_d;
    logic [13:0]           shadow_q [1:9];
    logic [13:0]           shadow_d [1:9];
    logic [3:0]            shadow7_hi_q, shadow7_hi_d;
    logic [13:0]           pub_q [1:9];
    logic [13:0]           pub_d [1:9];
    logic [3:0]            pub7_hi_q, pub7_hi_d;
    logic                  frame_committed_q, frame_committed_d;
    logic                  commit_pending_q, commit_pending_d;
    logic                  bad_slot_q, bad_slot_d;
    logic [OVERRUN_W-1:0]  overrun_q, overrun_d;
    logic                  wr_fire;
    logic                  slot_in_range;
    logic                  overrun_inc;

    assign wr_ready      = (state_q != COMMIT);
    assign wr_fire       = wr_valid & wr_ready;
    assign slot_in_range = (wr_slot >= 4'd1) && (wr_slot <= 4'd9);

    // Shadow bank write port; out-of-range slots are accepted but discarded
    always_comb begin
        shadow_d     = shadow_q;
        shadow7_hi_d = shadow7_hi_q;
        bad_slot_d   = 1'b0;
        if (wr_fire) begin
            if (slot_in_range) begin
                for (int i = 1; i <= 9; i++) begin
                    if (wr_slot == 4'(i)) begin
                        shadow_d[i] = wr_data[13:0];
                    end
                end
                if (wr_slot == 4'd7) begin
                    shadow7_hi_d = wr_data[17:14];
                end
            end else begin
                bad_slot_d = 1'b1;
            end
        end
    end

    // Frame sequencing: decide when to publish and count dropped frames
    always_comb begin
        state_d           = state_q;
        pub_d             = pub_q;
        pub7_hi_d         = pub7_hi_q;
        frame_committed_d = 1'b0;
        overrun_inc       = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = batch_open ? WAIT_BATCH : COMMIT;
                end
            end
            WAIT_BATCH: begin
                if (frame_tick) begin
                    overrun_inc = 1'b1;
                end
                if (!batch_open) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                pub_d             = shadow_q;
                pub7_hi_d         = shadow7_hi_q;
                frame_committed_d = 1'b1;
                state_d           = IDLE;
                if (frame_tick) begin
                    overrun_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        commit_pending_d = (state_d == WAIT_BATCH);
        overrun_d        = overrun_q;
        if (overrun_inc && (overrun_q != {OVERRUN_W{1'b1}})) begin
            overrun_d = overrun_q + OVERRUN_W'(1);
        end
    end

    // All state, shadow and published registers; reset forces the empty entity set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            for (int i = 1; i <= 9; i++) begin
                shadow_q[i] <= (i == 7) ? 14'h0 : EMPTY_WORD;
                pub_q[i]    <= (i == 7) ? 14'h0 : EMPTY_WORD;
            end
            shadow7_hi_q      <= EMPTY_ID;
            pub7_hi_q         <= EMPTY_ID;
            frame_committed_q <= 1'b0;
            commit_pending_q  <= 1'b0;
            bad_slot_q        <= 1'b0;
            overrun_q         <= '0;
        end else begin
            state_q           <= state_d;
            shadow_q          <= shadow_d;
            shadow7_hi_q      <= shadow7_hi_d;
            pub_q             <= pub_d;
            pub7_hi_q         <= pub7_hi_d;
            frame_committed_q <= frame_committed_d;
            commit_pending_q  <= commit_pending_d;
            bad_slot_q        <= bad_slot_d;
            overrun_q         <= overrun_d;
        end
    end

    assign entity_1        = pub_q[1];
    assign entity_2        = pub_q[2];
    assign entity_3        = pub_q[3];
    assign entity_4        = pub_q[4];
    assign entity_5        = pub_q[5];
    assign entity_6        = pub_q[6];
    assign entity_7        = {pub7_hi_q, pub_q[7]};
    assign entity_8_Flip   = pub_q[8];
    assign entity_9_Flip   = pub_q[9];
    assign frame_committed = frame_committed_q;
    assign commit_pending  = commit_pending_q;
    assign bad_slot        = bad_slot_q;
    assign overrun_count   = overrun_q;

endmodule

// File: tb/tb_entity_frame_publisher.sv
// Bench for entity_frame_publisher: directed frame/write scenarios, a
// frame-level reference model compared every cycle, and literal spot checks.
module tb_entity_frame_publisher;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wrValid = 1'b0;
    logic [3:0]  wrSlot = 4'd0;
    logic [17:0] wrData = 18'd0;
    logic        batchOpen = 1'b0;
    logic        frameTick = 1'b0;

    logic        wrReady, frameCommitted, commitPending, badSlot;
    logic [13:0] ent1, ent2, ent3, ent4, ent5, ent6, ent8, ent9;
    logic [17:0] ent7;
    logic [7:0]  overrunCount;

    logic        wrReady2, frameCommitted2, commitPending2, badSlot2;
    logic [13:0] e1b, e2b, e3b, e4b, e5b, e6b, e8b, e9b;
    logic [17:0] e7b;
    logic [1:0]  overrunCount2;

    int testsRun = 0;
    int testsFailed = 0;
    int fcCount = 0;
    int badCount = 0;

    entity_frame_publisher #(.EMPTY_ID(4'hF), .OVERRUN_W(8)) u_dut (
        .clk(clk), .reset(reset), .wr_valid(wrValid), .wr_ready(wrReady),
        .wr_slot(wrSlot), .wr_data(wrData), .batch_open(batchOpen), .frame_tick(frameTick),
        .entity_1(ent1), .entity_2(ent2), .entity_3(ent3), .entity_4(ent4),
        .entity_5(ent5), .entity_6(ent6), .entity_7(ent7),
        .entity_8_Flip(ent8), .entity_9_Flip(ent9),
        .frame_committed(frameCommitted), .commit_pending(commitPending),
        .bad_slot(badSlot), .overrun_count(overrunCount)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation
    entity_frame_publisher #(.EMPTY_ID(4'hF), .OVERRUN_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .wr_valid(wrValid), .wr_ready(wrReady2),
        .wr_slot(wrSlot), .wr_data(wrData), .batch_open(batchOpen), .frame_tick(frameTick),
        .entity_1(e1b), .entity_2(e2b), .entity_3(e3b), .entity_4(e4b),
        .entity_5(e5b), .entity_6(e6b), .entity_7(e7b),
        .entity_8_Flip(e8b), .entity_9_Flip(e9b),
        .frame_committed(frameCommitted2), .commit_pending(commitPending2),
        .bad_slot(badSlot2), .overrun_count(overrunCount2)
    );

    always #5 clk = ~clk;

    logic [17:0] dutEnt [1:9];
    always_comb begin
        dutEnt[1] = {4'b0, ent1};
        dutEnt[2] = {4'b0, ent2};
        dutEnt[3] = {4'b0, ent3};
        dutEnt[4] = {4'b0, ent4};
        dutEnt[5] = {4'b0, ent5};
        dutEnt[6] = {4'b0, ent6};
        dutEnt[7] = ent7;
        dutEnt[8] = {4'b0, ent8};
        dutEnt[9] = {4'b0, ent9};
    end

    // Reference model: a shadow bank, the published bank, and a publish request
    // that lands one edge after it is raised; writes are refused on that edge.
    logic [17:0] mShadow [1:9];
    logic [17:0] mOut [1:9];
    bit          mPublishNext;
    bit          mWaiting;
    int          mOverruns;
    bit          mFc;
    bit          mBad;

    task automatic modelReset();
        for (int i = 1; i <= 9; i++) begin
            mShadow[i] = (i == 7) ? 18'h3C000 : 18'h03C00;
            mOut[i]    = mShadow[i];
        end
        mPublishNext = 0;
        mWaiting     = 0;
        mOverruns    = 0;
        mFc          = 0;
        mBad         = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            modelReset();
        end else begin
            bit blocked;
            int idx;
            blocked = mPublishNext;
            mFc  = 0;
            mBad = 0;
            idx  = int'(wrSlot);
            if (wrValid && !blocked) begin
                if (idx >= 1 && idx <= 9) begin
                    mShadow[idx] = (idx == 7) ? wrData : {4'b0, wrData[13:0]};
                end else begin
                    mBad = 1;
                end
            end
            if (blocked) begin
                for (int i = 1; i <= 9; i++) mOut[i] = mShadow[i];
                mFc = 1;
                mPublishNext = 0;
                if (frameTick) mOverruns++;
            end else if (mWaiting) begin
                if (frameTick) mOverruns++;
                if (!batchOpen) begin
                    mWaiting = 0;
                    mPublishNext = 1;
                end
            end else if (frameTick) begin
                if (batchOpen) mWaiting = 1;
                else mPublishNext = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int i = 1; i <= 9; i++) begin
            checkOutput($sformatf("entity_%0d", i), 32'(dutEnt[i]), 32'(mOut[i]));
        end
        checkOutput("wr_ready", 32'(wrReady), 32'(!mPublishNext));
        checkOutput("commit_pending", 32'(commitPending), 32'(mWaiting));
        checkOutput("frame_committed", 32'(frameCommitted), 32'(mFc));
        checkOutput("bad_slot", 32'(badSlot), 32'(mBad));
        checkOutput("overrun_count", 32'(overrunCount), 32'((mOverruns > 255) ? 255 : mOverruns));
        checkOutput("overrun_count_w2", 32'(overrunCount2), 32'((mOverruns > 3) ? 3 : mOverruns));
    end

    // Pulse counters used by the directed checks
    always @(posedge clk) begin
        #1;
        if (frameCommitted) fcCount++;
        if (badSlot) badCount++;
    end

    task automatic applyStimulus(input logic valid, input logic [3:0] slot, input logic [17:0] data,
                                 input logic batch, input logic tick);
        wrValid   = valid;
        wrSlot    = slot;
        wrData    = data;
        batchOpen = batch;
        frameTick = tick;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 18'd0, batchOpen, 1'b0);
    endtask

    // Offer a write and hold it until the bank accepts it
    task automatic writeWord(input logic [3:0] slot, input logic [17:0] data, output int waits);
        bit accepted;
        waits     = 0;
        wrValid   = 1'b1;
        wrSlot    = slot;
        wrData    = data;
        frameTick = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            accepted = wrReady;
            @(negedge clk);
            if (!accepted) waits++;
        end
        if (!accepted) checkOutput("write_accept_timeout", 32'd0, 32'd1);
        wrValid = 1'b0;
    endtask

    initial begin
        int w;
        int fcBefore;
        int badBefore;

        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_entity_1", 32'(ent1), 32'h3C00);
        checkOutput("reset_entity_7", 32'(ent7), 32'h3C000);
        checkOutput("reset_overrun", 32'(overrunCount), 32'd0);
        reset = 1'b1;
        idleCycles(2);

        // 1: empty frame publish
        fcBefore = fcCount;
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b0, 1'b1);
        idleCycles(3);
        checkOutput("t1_commit_pulses", 32'(fcCount - fcBefore), 32'd1);
        checkOutput("t1_entity_8", 32'(ent8), 32'h3C00);
        checkOutput("t1_entity_7", 32'(ent7), 32'h3C000);

        // 2: writes become visible only after the next tick
        writeWord(4'd1, 18'h01A25, w);
        writeWord(4'd7, 18'h25F3C, w);
        idleCycles(1);
        checkOutput("t2_before_tick_entity_1", 32'(ent1), 32'h3C00);
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b0, 1'b1);
        idleCycles(2);
        checkOutput("t2_entity_1", 32'(ent1), 32'h1A25);
        checkOutput("t2_entity_7", 32'(ent7), 32'h25F3C);
        checkOutput("t2_entity_2", 32'(ent2), 32'h3C00);

        // 3: publish held off by an open batch
        writeWord(4'd3, 18'h00333, w);
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'd0, 18'd0, 1'b1, 1'b0);
            checkOutput("t3_pending_hold", 32'(commitPending), 32'd1);
        end
        checkOutput("t3_entity_3_held", 32'(ent3), 32'h3C00);
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t3_entity_3", 32'(ent3), 32'h0333);
        checkOutput("t3_overrun", 32'(overrunCount), 32'd0);

        // 4: dropped frames while the batch stays open
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'd0, 18'd0, 1'b1, 1'b1);
            applyStimulus(1'b0, 4'd0, 18'd0, 1'b1, 1'b0);
        end
        checkOutput("t4_overrun_3ticks", 32'(overrunCount), 32'd2);
        checkOutput("t4_overrun_w2_3ticks", 32'(overrunCount2), 32'd2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'd0, 18'd0, 1'b1, 1'b1);
            applyStimulus(1'b0, 4'd0, 18'd0, 1'b1, 1'b0);
        end
        checkOutput("t4_overrun_9ticks", 32'(overrunCount), 32'd8);
        checkOutput("t4_overrun_w2_sat", 32'(overrunCount2), 32'd3);
        fcBefore = fcCount;
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
        idleCycles(4);
        checkOutput("t4_single_commit", 32'(fcCount - fcBefore), 32'd1);

        // 5: bad slots and a write offered during the publish cycle
        badBefore = badCount;
        writeWord(4'd0, 18'h3FFFF, w);
        writeWord(4'd12, 18'h3FFFF, w);
        idleCycles(1);
        checkOutput("t5_bad_pulses", 32'(badCount - badBefore), 32'd2);
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b0, 1'b1);
        writeWord(4'd4, 18'h00444, w);
        checkOutput("t5_held_write_waits", 32'(w), 32'd1);
        checkOutput("t5_entity_4_old", 32'(ent4), 32'h3C00);
        checkOutput("t5_entity_1_kept", 32'(ent1), 32'h1A25);
        applyStimulus(1'b1, 4'd5, 18'h00555, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t5_entity_4", 32'(ent4), 32'h0444);
        checkOutput("t5_tick_write_entity_5", 32'(ent5), 32'h0555);

        // 6: reset while waiting on a batch
        batchOpen = 1'b1;
        writeWord(4'd9, 18'h00401, w);
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("t6_pending_before", 32'(commitPending), 32'd1);
        fcBefore = fcCount;
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_entity_9_reset", 32'(ent9), 32'h3C00);
        checkOutput("t6_pending_reset", 32'(commitPending), 32'd0);
        checkOutput("t6_entity_1_reset", 32'(ent1), 32'h3C00);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
        idleCycles(5);
        checkOutput("t6_no_commit", 32'(fcCount - fcBefore), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
